// File: rtl/cnn_pkg.sv
// Shared CNN datapath package: default sample width and the signed-max helper
// used by both the conv stage and the pooling stage.
//   CNN_DATA_W : default conv/ReLU sample width
//   MAX_W      : operand width of smax; callers sign-extend into it (DATA_W <= MAX_W)
package cnn_pkg;

  localparam int unsigned CNN_DATA_W = 16;
  localparam int unsigned MAX_W      = 32;

  // Signed maximum; ties return the (identical) operand value.
  function automatic logic signed [MAX_W-1:0] smax(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Stream bundle for the 2x2 max-pool stage.
//   in_valid/in_ready/in_data            : raster-order input samples
//   out_valid/out_ready/out_data/out_last : pooled samples, out_last on frame end
// master = upstream/downstream side (testbench), slave = pooling block.
interface maxpool2x2_stream_if
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = CNN_DATA_W
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/maxpool2x2_stream_row_buf.sv
// Row buffer holding horizontal pair maxima of the current even row.
//   clk          : write clock
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : asynchronous read port
// Contents are deliberately not reset: every entry is written on an even row
// before the following odd row reads it.
module pool_row_buf #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max pooling over a raster-order feature map.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : slave side of maxpool2x2_stream_if (input stream in, pooled stream out)
// Even columns park the sample in a pair register, odd columns form the
// horizontal pair max. Even rows store that max in the row buffer; odd rows
// combine it with the stored value and register the pooled result.
module maxpool2x2_stream
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8,
  parameter int unsigned DATA_W = CNN_DATA_W
) (
  input logic                clk,
  input logic                reset,
  maxpool2x2_stream_if.slave bus
);

  localparam int unsigned COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned BUF_N  = IMG_W / 2;
  localparam int unsigned BUF_AW = (BUF_N > 1) ? $clog2(BUF_N) : 1;

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic signed [DATA_W-1:0] pair;
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] pool_max;
  logic [DATA_W-1:0]        buf_rdata;
  logic [BUF_AW-1:0]        buf_addr;
  logic                     accept;
  logic                     col_end;
  logic                     row_end;
  logic                     buf_we;

  // Ready whenever the output register is free or being drained this cycle.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign col_end  = (col == COL_W'(IMG_W - 1));
  assign row_end  = (row == ROW_W'(IMG_H - 1));
  assign buf_addr = BUF_AW'(col >> 1);
  assign buf_we   = accept && col[0] && !row[0];

  assign pair_max = DATA_W'(smax(MAX_W'(pair), MAX_W'(bus.in_data)));
  assign pool_max = DATA_W'(smax(MAX_W'(pair_max), MAX_W'($signed(buf_rdata))));

  pool_row_buf #(
    .ENTRIES (BUF_N),
    .DATA_W  (DATA_W),
    .ADDR_W  (BUF_AW)
  ) u_row_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (buf_addr),
    .wdata (pair_max),
    .raddr (buf_addr),
    .rdata (buf_rdata)
  );

  // Position counters, pair register and registered output stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col           <= '0;
      row           <= '0;
      pair          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (accept) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          pair <= bus.in_data;
        end else if (row[0]) begin
          // A new result may overwrite the register in the same cycle it drains.
          bus.out_data  <= pool_max;
          bus.out_last  <= row_end && col_end;
          bus.out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream on a 4x4 frame: directed cases
// plus randomized data, valid gaps and backpressure against a pixel-array model.
module tb_maxpool2x2_stream;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned N  = W * H;

  typedef struct {
    int data;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  maxpool2x2_stream_if #(.DATA_W(DW)) bus ();

  maxpool2x2_stream #(
    .IMG_W  (W),
    .IMG_H  (H),
    .DATA_W (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   pix [N];
  int   pos = 0;
  bit   expect_valid = 1'b0;
  exp_t exp_q[$];
  int   got_q[$];

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: keep the frame as a pixel array; each odd/odd pixel closes a 2x2 window.
  task automatic model_accept(input int d);
    int r, c, m;
    exp_t e;
    pix[pos] = d;
    r = pos / W;
    c = pos % W;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      m = pix[pos];
      if (pix[pos-1] > m)   m = pix[pos-1];
      if (pix[pos-W] > m)   m = pix[pos-W];
      if (pix[pos-W-1] > m) m = pix[pos-W-1];
      e.data = m;
      e.last = (pos == N - 1);
      exp_q.push_back(e);
      expect_valid = 1'b1;
    end
    pos = (pos + 1) % N;
  endtask

  task automatic cycle(input bit iv, input int d, input bit ordy,
                       output bit acc, output bit ird, output int od);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = DW'(d);
    bus.out_ready = ordy;
    #1;
    ird = bus.in_ready;
    od  = int'(bus.out_data);
    if (expect_valid) begin
      check_eq("latency_valid", bus.out_valid, 1);
      expect_valid = 1'b0;
    end
    if (bus.out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", bus.out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", od, e.data);
        check_eq("out_last", bus.out_last, e.last);
      end
      got_q.push_back(od);
    end
    acc = iv && ird;
    if (acc) model_accept(d);
    @(posedge clk);
  endtask

  task automatic send_pixel(input int d, input int ordy_pct, input int gap_pct);
    bit acc, ird;
    int od;
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      cycle(($urandom_range(99) >= 32'(gap_pct)), d,
            ($urandom_range(99) < 32'(ordy_pct)), acc, ird, od);
    end
    if (!acc) check_eq("send_timeout", acc, 1);
  endtask

  task automatic drain();
    bit acc, ird;
    int od;
    for (int t = 0; t < 50 && (exp_q.size() != 0 || bus.out_valid); t++)
      cycle(1'b0, 0, 1'b1, acc, ird, od);
    check_eq("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rst_in_ready", bus.in_ready, 1);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_out_last", bus.out_last, 0);
    pos = 0;
    exp_q.delete();
    got_q.delete();
    expect_valid = 1'b0;
  endtask

  task automatic check_got(input string tag, input int want[$]);
    check_eq({tag, "_count"}, got_q.size(), want.size());
    for (int i = 0; i < want.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s_%0d", tag, i), got_q[i], want[i]);
  endtask

  initial begin
    bit acc, ird;
    int od;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Raster 1..16, no backpressure.
    do_reset();
    for (int v = 1; v <= 16; v++) send_pixel(v, 100, 0);
    drain();
    check_got("ramp", '{6, 8, 14, 16});

    // Uniform -5 with one -2: signed comparison.
    do_reset();
    for (int i = 0; i < 16; i++) send_pixel((i == 5) ? -2 : -5, 100, 0);
    drain();
    check_got("neg", '{-2, -5, -5, -5});

    // Three stall cycles while 6 is pending.
    do_reset();
    for (int v = 1; v <= 6; v++) send_pixel(v, 100, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 7, 1'b0, acc, ird, od);
      check_eq("stall_in_ready", ird, 0);
      check_eq("stall_out_data", od, 6);
      check_eq("stall_accept", acc, 0);
    end
    for (int v = 7; v <= 16; v++) send_pixel(v, 100, 0);
    drain();
    check_got("stall", '{6, 8, 14, 16});

    // Reset after 5 beats discards the partial frame.
    do_reset();
    for (int v = 101; v <= 105; v++) send_pixel(v, 100, 0);
    do_reset();
    for (int v = 1; v <= 16; v++) send_pixel(v, 100, 0);
    drain();
    check_got("midrst", '{6, 8, 14, 16});

    // Back-to-back frames: one accepted beat every cycle.
    do_reset();
    for (int v = 1; v <= 32; v++) begin
      cycle(1'b1, v, 1'b1, acc, ird, od);
      check_eq($sformatf("b2b_accept_%0d", v), acc, 1);
    end
    drain();
    check_got("b2b", '{6, 8, 14, 16, 22, 24, 30, 32});

    // Random signed data, random valid gaps and backpressure.
    do_reset();
    for (int f = 0; f < 4; f++)
      for (int i = 0; i < 16; i++)
        send_pixel(int'($urandom_range(65535)) - 32768, 60, 30);
    drain();
    check_eq("rand_count", got_q.size(), 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
